// File: rtl/arb_mux_reg_if.sv
// Handshake bundle for arb_mux_reg: NUM_IN requesters in, one registered word out.
// The slave modport is the arbiter's view. The master modport is the producer/consumer side.
interface arb_mux_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int SEL_W      = 2
) ();
    logic [NUM_IN-1:0]            in_valid;
    logic [NUM_IN*DATA_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]            in_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]             out_sel;
    logic                         out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/arb_mux_reg.sv
// Arbitrated N:1 registered select. Policy is round-robin (MODE 0) or fixed priority (MODE 1).
// Latency is 1 cycle. in_ready is gated off while the output register is stalled; drain and load happen in the same cycle.
module arb_mux_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int SEL_W      = 2,
    parameter int MODE       = 0
) (
    input  logic         clk,
    input  logic         rst,
    arb_mux_reg_if.slave bus
);
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_sel_q, out_sel_d;
    logic [SEL_W-1:0]      ptr_q, ptr_d;

    logic                  lo_vld, hi_vld, gnt_vld, can_load, xfer;
    logic [SEL_W-1:0]      lo_idx, hi_idx, gnt_idx, ptr_nxt;
    logic [DATA_WIDTH-1:0] gnt_dat;
    logic [NUM_IN-1:0]     rdy;

    // Two scans: the lowest requester overall, and the lowest requester at or above ptr.
    always_comb begin
        lo_vld = 1'b0;
        lo_idx = '0;
        hi_vld = 1'b0;
        hi_idx = '0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SEL_W'(i);
            end
            if (bus.in_valid[i] && (i >= int'(ptr_q))) begin
                hi_vld = 1'b1;
                hi_idx = SEL_W'(i);
            end
        end
    end

    // In round-robin mode, fall back to the lowest requester when no requester sits at or above ptr. This is the wrap.
    assign gnt_vld  = lo_vld;
    assign gnt_idx  = ((MODE == 0) && hi_vld) ? hi_idx : lo_idx;
    assign can_load = !out_valid_q || bus.out_ready;
    assign xfer     = gnt_vld && can_load && !rst;
    assign ptr_nxt  = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);

    always_comb begin
        gnt_dat = '0;
        rdy     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_dat = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                rdy[i]  = xfer;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_dat;
            out_sel_d   = gnt_idx;
            if (MODE == 0) begin
                ptr_d = ptr_nxt;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_arb_mux_reg.sv
// Three arbiters share one stimulus: round-robin with 4 inputs, fixed priority with 4 inputs, and round-robin with 3 inputs.
// Each one is compared every cycle against a queue-free behavioural model.
module tb_arb_mux_reg;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic        ordy;
    logic [31:0] dat [4];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    arb_mux_reg_if #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_W(2)) rr_if ();
    arb_mux_reg_if #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_W(2)) fp_if ();
    arb_mux_reg_if #(.DATA_WIDTH(32), .NUM_IN(3), .SEL_W(2)) w3_if ();

    assign rr_if.in_valid  = vld;
    assign rr_if.in_data   = {dat[3], dat[2], dat[1], dat[0]};
    assign rr_if.out_ready = ordy;
    assign fp_if.in_valid  = vld;
    assign fp_if.in_data   = {dat[3], dat[2], dat[1], dat[0]};
    assign fp_if.out_ready = ordy;
    assign w3_if.in_valid  = vld[2:0];
    assign w3_if.in_data   = {dat[2], dat[1], dat[0]};
    assign w3_if.out_ready = ordy;

    arb_mux_reg #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(0)) u_rr (.clk(clk), .rst(rst), .bus(rr_if));
    arb_mux_reg #(.DATA_WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) u_fp (.clk(clk), .rst(rst), .bus(fp_if));
    arb_mux_reg #(.DATA_WIDTH(32), .NUM_IN(3), .SEL_W(2), .MODE(0)) u_w3 (.clk(clk), .rst(rst), .bus(w3_if));

    logic [3:0]  a_rdy [3];
    logic        a_ov  [3];
    logic [31:0] a_od  [3];
    logic [1:0]  a_os  [3];
    assign a_rdy[0] = rr_if.in_ready;
    assign a_rdy[1] = fp_if.in_ready;
    assign a_rdy[2] = {1'b0, w3_if.in_ready};
    assign a_ov[0] = rr_if.out_valid;
    assign a_ov[1] = fp_if.out_valid;
    assign a_ov[2] = w3_if.out_valid;
    assign a_od[0] = rr_if.out_data;
    assign a_od[1] = fp_if.out_data;
    assign a_od[2] = w3_if.out_data;
    assign a_os[0] = rr_if.out_sel;
    assign a_os[1] = fp_if.out_sel;
    assign a_os[2] = w3_if.out_sel;

    // Model state per instance: register contents and the round-robin start point.
    logic        m_v [3];
    logic [31:0] m_d [3];
    int          m_s [3];
    int          m_p [3];
    logic [3:0]  seen_rdy [3];

    function automatic int cfg_n(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic int cfg_mode(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int mgrant(input int n, input int mode, input int ptr, input logic [3:0] v);
        int  g;
        logic found;
        int  idx;
        g = -1;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = (mode == 1) ? k : (ptr + k) % n;
            if (!found && v[idx]) begin
                g = idx;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [3:0] mask;
        logic [3:0] v;
        logic [3:0] er;
        logic       can;
        int         g;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            mask = (cfg_n(k) == 3) ? 4'b0111 : 4'b1111;
            v = vld & mask;
            er = '0;
            seen_rdy[k] = a_rdy[k];
            if (rst) begin
                m_v[k] = 1'b0;
                m_d[k] = '0;
                m_s[k] = 0;
                m_p[k] = 0;
            end else begin
                can = !m_v[k] || ordy;
                g = mgrant(cfg_n(k), cfg_mode(k), m_p[k], v);
                if (can && g >= 0) begin
                    er[g] = 1'b1;
                    m_v[k] = 1'b1;
                    m_d[k] = dat[g];
                    m_s[k] = g;
                    if (cfg_mode(k) == 0) m_p[k] = (g + 1) % cfg_n(k);
                end else if (m_v[k] && ordy) begin
                    m_v[k] = 1'b0;
                end
            end
            chk($sformatf("in_ready[dut%0d]", k), 32'(a_rdy[k]), 32'(er));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid[dut%0d]", k), 32'(a_ov[k]), 32'(m_v[k]));
            chk($sformatf("out_data[dut%0d]", k), a_od[k], m_d[k]);
            chk($sformatf("out_sel[dut%0d]", k), 32'(a_os[k]), 32'(m_s[k]));
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_os;
        logic [1:0] e_fp;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Columns: reset, in_valid, expected rr in_ready, rr out_valid, rr out_sel, fixed-priority out_sel.
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 2'd0, 2'd0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 2'd1, 2'd0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 2'd2, 2'd0};
        tbl[5]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 2'd3, 2'd0};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 2'd0, 2'd0};
        tbl[7]  = '{1'b0, 4'b1010, 4'b0010, 1'b1, 2'd1, 2'd1};
        tbl[8]  = '{1'b0, 4'b1010, 4'b1000, 1'b1, 2'd3, 2'd1};
        tbl[9]  = '{1'b0, 4'b1000, 4'b1000, 1'b1, 2'd3, 2'd3};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 2'd3, 2'd3};

        rst = 1'b1;
        vld = '0;
        ordy = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = 32'hA0 + 32'(i);
        for (int k = 0; k < 3; k++) begin
            m_v[k] = 1'b0; m_d[k] = '0; m_s[k] = 0; m_p[k] = 0; seen_rdy[k] = '0;
        end

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].r;
            vld = tbl[i].v;
            tick();
            chk($sformatf("tbl%0d_rr_rdy", i), 32'(seen_rdy[0]), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_rr_ov", i), 32'(a_ov[0]), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_rr_sel", i), 32'(a_os[0]), 32'(tbl[i].e_os));
            chk($sformatf("tbl%0d_rr_dat", i), a_od[0], tbl[i].r ? 32'h0 : 32'hA0 + 32'(tbl[i].e_os));
            chk($sformatf("tbl%0d_fp_sel", i), 32'(a_os[1]), 32'(tbl[i].e_fp));
        end

        // Back-pressure: hold a word from ch2 through a 5-cycle stall, then drain and load in the same cycle.
        dat[2] = 32'h55;
        vld = 4'b0100;
        ordy = 1'b1;
        tick();
        chk("bp_load_sel", 32'(a_os[0]), 32'd2);
        ordy = 1'b0;
        vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stall_rdy", 32'(seen_rdy[0]), 32'd0);
            chk("bp_stall_dat", a_od[0], 32'h55);
            chk("bp_stall_sel", 32'(a_os[0]), 32'd2);
            chk("bp_stall_ov", 32'(a_ov[0]), 32'd1);
        end
        ordy = 1'b1;
        tick();
        chk("bp_release_rdy", 32'(seen_rdy[0]), 32'b1000);
        chk("bp_release_ov", 32'(a_ov[0]), 32'd1);
        chk("bp_release_sel", 32'(a_os[0]), 32'd3);

        // Wrap on three inputs: after ch2, the next grant must be ch0.
        rst = 1'b1; vld = '0;
        tick();
        rst = 1'b0; vld = 4'b0100;
        tick();
        chk("wrap_sel_ch2", 32'(a_os[2]), 32'd2);
        vld = 4'b1111;
        tick();
        chk("wrap_rdy_ch0", 32'(seen_rdy[2]), 32'b0001);
        chk("wrap_sel_ch0", 32'(a_os[2]), 32'd0);

        // Sparse: a single pulse on ch1, then idle.
        rst = 1'b1; vld = '0;
        tick();
        rst = 1'b0; vld = 4'b0010;
        tick();
        chk("sparse_ov", 32'(a_ov[0]), 32'd1);
        chk("sparse_sel", 32'(a_os[0]), 32'd1);
        vld = '0;
        tick();
        chk("sparse_drain_ov", 32'(a_ov[0]), 32'd0);
        chk("sparse_hold_dat", a_od[0], dat[1]);

        // Reset while a grant is pending drops the word and restarts at ch0.
        vld = 4'b1111;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_rdy", 32'(seen_rdy[0]), 32'd0);
        chk("rstmid_ov", 32'(a_ov[0]), 32'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_first_sel", 32'(a_os[0]), 32'd0);

        // Random traffic with occasional reset and back-pressure.
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            vld  = 4'($urandom_range(0, 15));
            ordy = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 4; j++) dat[j] = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised, registered N:1 select stage that generalises the processor's 2:1 datapath muxes into an arbitrated, flow-controlled block. It chooses one of NUM_IN valid sources per cycle under round-robin or fixed-priority policy, captures the winner's data and index in an output register, and presents it downstream with a valid/ready handshake. It is intended for shared write-back and memory-request paths where several producers compete for one consumer.

## Interface
- DATA_WIDTH, 32, width of each data word
- NUM_IN, 4, number of input channels (2..16)
- SEL_W, 2, width of out_sel; must satisfy 2**SEL_W >= NUM_IN
- MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  NUM_IN  per-channel request
- in_data  input  NUM_IN*DATA_WIDTH  flattened; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_ready  output  NUM_IN  per-channel accept; one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  DATA_WIDTH  registered winner data
- out_sel  output  SEL_W  registered winner index
- out_ready  input  1  downstream accepts

## Operation
- State: output register (out_valid, out_data, out_sel) and, in MODE 0, priority pointer ptr (SEL_W bits).
- Reset (rst=1 at edge): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 during any cycle with rst=1.
- can_load = !out_valid || out_ready.
- Grant (combinational): MODE 0 — first i with in_valid[i]=1 scanning ptr, ptr+1, … NUM_IN-1, 0, … ptr-1; MODE 1 — lowest i with in_valid[i]=1. No valid input → no grant.
- in_ready[g]=1 only for granted g and only when can_load=1; all other bits 0. Transfer on channel g occurs when in_valid[g] && in_ready[g].
- On transfer: out_data ← in_data[g], out_sel ← g, out_valid ← 1; MODE 0: ptr ← (g+1) mod NUM_IN (wraps NUM_IN-1 → 0, including non-power-of-two NUM_IN). MODE 1: ptr unused, held at 0.
- No transfer and out_valid && out_ready: out_valid ← 0; out_data, out_sel hold last value.
- Stall (out_valid && !out_ready): out_data, out_sel, out_valid, ptr hold; all in_ready=0.
- Simultaneous drain and load (out_valid && out_ready && new grant): register overwritten with new word, out_valid stays 1 — no bubble.
- ptr advances only on a transfer, never on idle or stall cycles.
- Inputs are not required to hold in_valid when not granted; block imposes no rule on withdrawn requests.

## Timing
- Latency: input transfer at edge N → word visible on out_data/out_sel with out_valid=1 after edge N (registered, 1 cycle).
- Throughput: one word per cycle while out_ready=1 and any in_valid=1.
- in_ready depends combinationally on in_valid, ptr, out_valid, out_ready; outputs out_* are purely registered.
- Reset asserted mid-transfer: reset wins; word is dropped, out_valid=0 next cycle, ptr=0.
- Fairness (MODE 0): with all channels continuously valid and out_ready=1, grants cycle 0,1,…,NUM_IN-1,0,… ; any continuously valid channel waits at most NUM_IN-1 transfers.

## Test plan
- Reset: drive in_valid=4'b1111, rst=1 for 2 cycles → in_ready=0, out_valid=0, out_data=0, out_sel=0; first grant after release is channel 0.
- Round-robin rotation (MODE 0, NUM_IN=4): all valid, out_ready=1, in_data[i]=0xA0+i → out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0,0xA1,0xA2,0xA3,0xA0.
- Fixed priority (MODE 1): in_valid=4'b1010 continuously → out_sel=1 every cycle; channel 3 never granted until in_valid[1] drops, then out_sel=3.
- Back-pressure: load word 0x55 from ch2, hold out_ready=0 for 5 cycles with new requests → out_data=0x55, out_sel=2 stable, in_ready=0, ptr unchanged; release → next grant ch3 same cycle, out_valid never drops.
- Wrap with NUM_IN=3, SEL_W=2, MODE 0: grant ch2 → next grant with all valid is ch0 (out_sel never 3).
- Sparse traffic: single pulse in_valid[1] with out_ready=1 → one cycle out_valid=1, out_sel=1, then out_valid=0 and out_data holds value.
